// File: rtl/io_bridge_pkg.sv
// Shared types and default register map for the memory-mapped IO port bridge.
package io_bridge_pkg;

  typedef enum logic {
    StStable   = 1'b0,
    StCounting = 1'b1
  } db_state_e;

  localparam logic [31:0] DefaultAddrPortout = 32'h0000_0FF0;
  localparam logic [31:0] DefaultAddrPortin  = 32'h0000_0FF4;
  localparam logic [31:0] DefaultAddrStatus  = 32'h0000_0FF8;

  // Word compare: callers pass address bits [31:2] only.
  function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/io_port_bridge_if.sv
// Processor-side load/store bus seen by the IO port bridge.
interface io_port_bridge_if;

  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );

endinterface

// File: rtl/debounce_fsm.sv
// Two-flop synchronizer plus debounce FSM; in_reg only follows input that stays
// stable for DEBOUNCE_CYCLES consecutive synchronized samples.
module debounce_fsm
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_in,
  output logic [7:0] in_reg,
  output logic       counting,
  output logic       accept
);

  localparam logic [7:0] LastCnt = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] cand;
  logic [7:0] cnt;
  db_state_e  state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      in_reg <= '0;
      state  <= StStable;
    end else begin
      sync1 <= port_in;
      sync2 <= sync1;
      unique case (state)
        StStable: begin
          if (sync2 != in_reg) begin
            cand  <= sync2;
            cnt   <= 8'd1;
            state <= StCounting;
          end
        end
        StCounting: begin
          if (sync2 == cand) begin
            if (cnt == LastCnt) begin
              in_reg <= cand;
              state  <= StStable;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else if (sync2 == in_reg) begin
            // Input bounced back to the accepted value: drop the candidate silently.
            cnt   <= '0;
            state <= StStable;
          end else begin
            cand <= sync2;
            cnt  <= 8'd1;
          end
        end
      endcase
    end
  end

  assign counting = (state == StCounting);
  assign accept   = counting && (sync2 == cand) && (cnt == LastCnt);

endmodule

// File: rtl/io_port_bridge.sv
// Memory-mapped IO bridge: output register, debounced input register and status.
// Define IO_BRIDGE_PORTOUT_READBACK_EN to make the output register readable.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] ADDR_PORTOUT    = DefaultAddrPortout,
  parameter logic [31:0] ADDR_PORTIN     = DefaultAddrPortin,
  parameter logic [31:0] ADDR_STATUS     = DefaultAddrStatus
) (
  input  logic                    clk,
  input  logic                    reset,
  io_port_bridge_if.slave         bus,
  input  logic [7:0]              PortIn,
  output logic [31:0]             PortOut,
  output logic                    InputNew
);

  logic       hit_out;
  logic       hit_in;
  logic       hit_st;
  logic [7:0] in_reg;
  logic       counting;
  logic       accept;
  logic       status_clear;
  logic       unused_addr_lsb;

  debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .port_in (PortIn),
    .in_reg  (in_reg),
    .counting(counting),
    .accept  (accept)
  );

  assign unused_addr_lsb = ^bus.Address[1:0];

  assign hit_out = word_match(bus.Address[31:2], ADDR_PORTOUT[31:2]);
  assign hit_in  = word_match(bus.Address[31:2], ADDR_PORTIN[31:2]);
  assign hit_st  = word_match(bus.Address[31:2], ADDR_STATUS[31:2]);
  assign bus.Hit = hit_out | hit_in | hit_st;

  assign status_clear = bus.MemRead && hit_st;

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead) begin
      if (hit_in) begin
        bus.ReadData = {24'b0, in_reg};
      end else if (hit_st) begin
        bus.ReadData = {30'b0, counting, InputNew};
      end else if (hit_out) begin
`ifdef IO_BRIDGE_PORTOUT_READBACK_EN
        bus.ReadData = PortOut;
`else
        bus.ReadData = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut  <= '0;
      InputNew <= 1'b0;
    end else begin
      if (bus.MemWrite && hit_out) begin
        PortOut <= bus.WriteData;
      end
      // A fresh acceptance outranks a read-to-clear on the same edge.
      if (accept) begin
        InputNew <= 1'b1;
      end else if (status_clear) begin
        InputNew <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge (DEBOUNCE_CYCLES = 4).
module tb_io_port_bridge;

  logic        clk;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        InputNew;
  logic [31:0] rd;
  logic [31:0] rb_exp;

  int n_checks = 0;
  int n_fail   = 0;

  io_port_bridge_if bus ();

  io_port_bridge #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PortIn  (PortIn),
    .PortOut (PortOut),
    .InputNew(InputNew)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    bus.Address = addr;
    bus.MemRead = 1'b1;
    #1;
    data = bus.ReadData;
    bus.MemRead = 1'b0;
  endtask

  initial begin
`ifdef IO_BRIDGE_PORTOUT_READBACK_EN
    rb_exp = 32'h0000_1234;
`else
    rb_exp = 32'h0000_0000;
`endif
    reset         = 1'b0;
    PortIn        = 8'h00;
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    #2;
    check("rst_portout", PortOut, 32'h0);
    check("rst_inputnew", {31'b0, InputNew}, 32'h0);
    check("rst_hit_addr0", {31'b0, bus.Hit}, 32'h0);
    peek(32'h0FF4, rd);
    check("rst_portin_rd", rd, 32'h0);
    peek(32'h0FF8, rd);
    check("rst_status_rd", rd, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    step();

    // Stores
    bus.Address   = 32'h0FF0;
    bus.WriteData = 32'hDEAD_BEEF;
    bus.MemWrite  = 1'b1;
    #1;
    check("hit_portout", {31'b0, bus.Hit}, 32'h1);
    step();
    check("store_portout", PortOut, 32'hDEAD_BEEF);
    bus.Address   = 32'h0FF4;
    bus.WriteData = 32'h0000_CAFE;
    step();
    check("store_other_addr", PortOut, 32'hDEAD_BEEF);
    bus.Address   = 32'h0FF2;
    bus.WriteData = 32'h0000_1234;
    step();
    check("store_lsb_ignored", PortOut, 32'h0000_1234);
    bus.MemWrite = 1'b0;

    // Decode and readback
    peek(32'h0FF0, rd);
    check("portout_readback", rd, rb_exp);
    check("portout_read_hit", {31'b0, bus.Hit}, 32'h1);
    bus.Address = 32'h0FFC;
    #1;
    check("miss_hit_0ffc", {31'b0, bus.Hit}, 32'h0);
    peek(32'h0FFC, rd);
    check("miss_rd_0ffc", rd, 32'h0);
    bus.Address = 32'h0FEC;
    #1;
    check("miss_hit_0fec", {31'b0, bus.Hit}, 32'h0);
    bus.Address = 32'h0FF8;
    #1;
    check("status_no_read_rd", bus.ReadData, 32'h0);

    // Debounce 00 -> A5, accepted at edge 6
    PortIn = 8'hA5;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e < 6) check($sformatf("a5_no_flag_e%0d", e), {31'b0, InputNew}, 32'h0);
      if (e == 2) begin
        peek(32'h0FF8, rd);
        check("a5_status_e2", rd, 32'h0);
      end
      if (e == 3) begin
        peek(32'h0FF8, rd);
        check("a5_status_e3", rd, 32'h2);
      end
      if (e == 6) begin
        check("a5_flag_e6", {31'b0, InputNew}, 32'h1);
        peek(32'h0FF4, rd);
        check("a5_portin_rd", rd, 32'h0000_00A5);
        peek(32'h0FF8, rd);
        check("a5_status_e6", rd, 32'h1);
      end
    end

    // Read-to-clear
    bus.Address = 32'h0FF8;
    bus.MemRead = 1'b1;
    #1;
    check("clear_status_rd", bus.ReadData, 32'h1);
    step();
    bus.MemRead = 1'b0;
    check("clear_flag", {31'b0, InputNew}, 32'h0);

    // Back to 00, then clear
    PortIn = 8'h00;
    repeat (6) step();
    check("zero_flag", {31'b0, InputNew}, 32'h1);
    peek(32'h0FF4, rd);
    check("zero_portin_rd", rd, 32'h0);
    bus.Address = 32'h0FF8;
    bus.MemRead = 1'b1;
    step();
    bus.MemRead = 1'b0;
    check("zero_clear", {31'b0, InputNew}, 32'h0);

    // Glitch: 3C for 3 raw cycles is rejected
    PortIn = 8'h3C;
    repeat (3) step();
    PortIn = 8'h00;
    peek(32'h0FF8, rd);
    check("glitch_status_e3", rd, 32'h2);
    step();
    peek(32'h0FF8, rd);
    check("glitch_status_e4", rd, 32'h2);
    step();
    step();
    peek(32'h0FF8, rd);
    check("glitch_status_e6", rd, 32'h0);
    repeat (4) step();
    check("glitch_no_flag", {31'b0, InputNew}, 32'h0);
    peek(32'h0FF4, rd);
    check("glitch_portin_rd", rd, 32'h0);

    // Status read on the acceptance edge: set wins
    PortIn = 8'h5A;
    repeat (5) step();
    bus.Address = 32'h0FF8;
    bus.MemRead = 1'b1;
    #1;
    check("race_status_rd", bus.ReadData, 32'h2);
    step();
    bus.MemRead = 1'b0;
    check("race_flag_kept", {31'b0, InputNew}, 32'h1);
    peek(32'h0FF4, rd);
    check("race_portin_rd", rd, 32'h0000_005A);

    // Reset mid-count
    PortIn = 8'hFF;
    repeat (4) step();
    peek(32'h0FF8, rd);
    check("midcnt_status", rd, 32'h3);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_portout", PortOut, 32'h0);
    check("midrst_flag", {31'b0, InputNew}, 32'h0);
    peek(32'h0FF8, rd);
    check("midrst_status", rd, 32'h0);
    peek(32'h0FF4, rd);
    check("midrst_portin_rd", rd, 32'h0);
    step();
    check("midrst_hold_portout", PortOut, 32'h0);
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) begin
        check("post_rst_no_flag_e5", {31'b0, InputNew}, 32'h0);
        peek(32'h0FF4, rd);
        check("post_rst_portin_e5", rd, 32'h0);
      end
      if (e == 6) begin
        check("post_rst_flag_e6", {31'b0, InputNew}, 32'h1);
        peek(32'h0FF4, rd);
        check("post_rst_portin_e6", rd, 32'h0000_00FF);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples before PortIn is accepted; legal range 2..255.
REQ-002 Parameter ADDR_PORTOUT, default 32'h0000_0FF0, word address of the output register.
REQ-003 Parameter ADDR_PORTIN, default 32'h0000_0FF4, word address of the debounced input register.
REQ-004 Parameter ADDR_STATUS, default 32'h0000_0FF8, word address of the status register.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 Address  input  32  byte address from the processor ALU result.
REQ-008 WriteData  input  32  store data (processor rt value).
REQ-009 MemWrite  input  1  store strobe, sampled on clk.
REQ-010 MemRead  input  1  load strobe.
REQ-011 PortIn  input  8  raw asynchronous external input.
REQ-012 ReadData  output  32  combinational load data for the processor write-back mux.
REQ-013 Hit  output  1  combinational; high when Address[31:2] equals any of the three register addresses' [31:2].
REQ-014 PortOut  output  32  registered output port.
REQ-015 InputNew  output  1  registered; the new-input flag.

Function
REQ-016 Address decode SHALL compare Address[31:2] only; Address[1:0] ignored.
REQ-017 A store to ADDR_PORTOUT (MemWrite=1) SHALL load WriteData into PortOut at the same edge; stores to other addresses SHALL not change PortOut.
REQ-018 PortIn SHALL pass through a 2-flop synchronizer before any use.
REQ-019 The debounce FSM SHALL have states STABLE and COUNTING, with an 8-bit counter cnt, a candidate register cand and an accepted register in_reg.
REQ-020 STABLE: if sync != in_reg, go to COUNTING with cand<=sync and cnt<=1; otherwise hold.
REQ-021 COUNTING, sync == cand: if cnt == DEBOUNCE_CYCLES-1, set in_reg<=cand, set InputNew<=1 and go to STABLE; else cnt<=cnt+1.
REQ-022 COUNTING, sync != cand and sync == in_reg: go to STABLE with cnt<=0 (glitch rejected, no flag).
REQ-023 COUNTING, sync != cand and sync != in_reg: cand<=sync and cnt<=1.
REQ-024 Latency: a raw change held steady updates in_reg at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples it.
REQ-025 A load from ADDR_PORTIN SHALL return {24'b0, in_reg}.
REQ-026 A load from ADDR_STATUS SHALL return {30'b0, state==COUNTING, InputNew}.
REQ-027 A load from ADDR_STATUS with MemRead=1 SHALL clear InputNew at that edge (read-to-clear).
REQ-028 If a clear and a debounce acceptance fall on the same edge, the set wins and InputNew stays 1.
REQ-029 ReadData SHALL be 0 when Hit=0 or MemRead=0.

Reset
REQ-030 On reset low: PortOut=0, InputNew=0, in_reg=0, cand=0, cnt=0, both synchronizer stages=0, state=STABLE, all asynchronously.
REQ-031 Reset asserted in COUNTING SHALL abort the count with no flag; after release the FSM restarts from STABLE.

Configuration
REQ-032 Macro IO_BRIDGE_PORTOUT_READBACK_EN: when defined, a load from ADDR_PORTOUT returns PortOut and asserts Hit; when undefined, ADDR_PORTOUT is write-only, such a load returns 0, and Hit still asserts.

Structure
REQ-033 Package io_bridge_pkg SHALL hold the debounce state enum and the default address constants.
REQ-034 Sub-module debounce_fsm SHALL contain the synchronizer, the FSM, cnt, cand and in_reg; the top level holds the decode, PortOut, InputNew and the read mux.

Verification
REQ-035 Reset release, then a store of 32'hDEAD_BEEF to 32'h0FF0 -> PortOut=32'hDEADBEEF after one edge; a store to 32'h0FF4 -> PortOut unchanged.
REQ-036 PortIn 8'h00 -> 8'hA5 held steady, DEBOUNCE_CYCLES=4 -> in_reg=8'hA5 and InputNew=1 at edge 6; a load from 32'h0FF4 returns 32'h0000_00A5.
REQ-037 PortIn pulses to 8'h3C for 3 cycles, then returns to 8'h00 -> in_reg stays 8'h00, InputNew stays 0, and status bit1 is seen high and then low.
REQ-038 A load from 32'h0FF8 with InputNew=1 -> returns 32'h1, and InputNew=0 at the next edge; a status read on the same edge as an acceptance -> InputNew stays 1.
REQ-039 Reset asserted mid-count (cnt=2) -> all outputs 0 immediately, with no acceptance after release unless the input is held a further 6 edges.
REQ-040 A load from 32'h0FF0 with PortOut=32'h1234 -> returns 32'h1234 with the macro defined, and 0 without it; Hit=1 in both builds.
